// File: rtl/hazard_ctrl_if.sv
// D-stage decode fields from the pipeline and the hazard controller's stall and
// forwarding selects, grouped as one bundle.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int TW     = 2
);
    logic              d_valid;
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic              d_use_rs;
    logic              d_use_rt;
    logic [TW-1:0]     d_tuse_rs;
    logic [TW-1:0]     d_tuse_rt;
    logic              d_wen;
    logic [REG_AW-1:0] d_dst;
    logic [TW-1:0]     d_tnew;
    logic              d_md_use;
    logic              d_md_start;
    logic              d_md_div;
    logic              stall;
    logic [1:0]        fwd_rs_d;
    logic [1:0]        fwd_rt_d;
    logic [1:0]        fwd_rs_e;
    logic [1:0]        fwd_rt_e;
    logic              fwd_rt_m;
    logic              md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
               d_wen, d_dst, d_tnew, d_md_use, d_md_start, d_md_div,
        input  stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_use_rs, d_use_rt, d_tuse_rs, d_tuse_rt,
               d_wen, d_dst, d_tnew, d_md_use, d_md_start, d_md_div,
        output stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Tnew/Tuse hazard controller: shadows E/M/W producers, derives stall and forwarding
// selects, and holds the multiply/divide busy counter.
module hazard_ctrl #(
    parameter int REG_AW   = 5,
    parameter int TW       = 2,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave hz
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    // Tuse is consumed only in D; later stages keep just what forwarding reads.
    logic              e_vld_r, e_use_rs_r, e_use_rt_r, e_md_start_r, e_md_div_r;
    logic [REG_AW-1:0] e_dst_r, e_rs_r, e_rt_r;
    logic [TW-1:0]     e_tnew_r;
    logic              m_vld_r, m_use_rt_r;
    logic [REG_AW-1:0] m_dst_r, m_rt_r;
    logic [TW-1:0]     m_tnew_r;
    logic              w_vld_r;
    logic [REG_AW-1:0] w_dst_r;
    logic [TW-1:0]     w_tnew_r;
    logic [CW-1:0]     cnt_r;

    logic              e_live_s, m_live_s, w_live_s;
    logic              md_busy_s, md_stall_s, stall_s, e_load_s;
    logic [2:0]        rs_d_s, rt_d_s;
    logic [1:0]        rs_e_s, rt_e_s;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
        logic [TW-1:0] r;
        if (v == '0) r = '0;
        else         r = v - TW'(1);
        return r;
    endfunction

    // Returns {stall, fwd code}; the newest matching stage shadows older ones.
    function automatic logic [2:0] pick_d(input logic hit_e, input logic hit_m, input logic hit_w,
                                          input logic [TW-1:0] tn_e, input logic [TW-1:0] tn_m,
                                          input logic [TW-1:0] tn_w, input logic [TW-1:0] tuse);
        logic [2:0] r;
        if (hit_e)      r = {tn_e > tuse, (tn_e == '0) ? 2'd1 : 2'd0};
        else if (hit_m) r = {tn_m > tuse, (tn_m == '0) ? 2'd2 : 2'd0};
        else if (hit_w) r = {tn_w > tuse, (tn_w == '0) ? 2'd3 : 2'd0};
        else            r = 3'b000;
        return r;
    endfunction

    function automatic logic [1:0] pick_e(input logic hit_m, input logic hit_w,
                                          input logic [TW-1:0] tn_m, input logic [TW-1:0] tn_w);
        logic [1:0] r;
        if (hit_m)      r = (tn_m == '0) ? 2'd1 : 2'd0;
        else if (hit_w) r = (tn_w == '0) ? 2'd2 : 2'd0;
        else            r = 2'd0;
        return r;
    endfunction

    assign e_live_s  = e_vld_r && (e_dst_r != '0);
    assign m_live_s  = m_vld_r && (m_dst_r != '0);
    assign w_live_s  = w_vld_r && (w_dst_r != '0);
    assign md_busy_s = (cnt_r != '0);

    // Hazard resolution for D and E sources plus the MDU stall.
    always_comb begin
        rs_d_s = pick_d(hz.d_use_rs && e_live_s && (e_dst_r == hz.d_rs),
                        hz.d_use_rs && m_live_s && (m_dst_r == hz.d_rs),
                        hz.d_use_rs && w_live_s && (w_dst_r == hz.d_rs),
                        e_tnew_r, m_tnew_r, w_tnew_r, hz.d_tuse_rs);
        rt_d_s = pick_d(hz.d_use_rt && e_live_s && (e_dst_r == hz.d_rt),
                        hz.d_use_rt && m_live_s && (m_dst_r == hz.d_rt),
                        hz.d_use_rt && w_live_s && (w_dst_r == hz.d_rt),
                        e_tnew_r, m_tnew_r, w_tnew_r, hz.d_tuse_rt);
        rs_e_s = pick_e(e_use_rs_r && m_live_s && (m_dst_r == e_rs_r),
                        e_use_rs_r && w_live_s && (w_dst_r == e_rs_r),
                        m_tnew_r, w_tnew_r);
        rt_e_s = pick_e(e_use_rt_r && m_live_s && (m_dst_r == e_rt_r),
                        e_use_rt_r && w_live_s && (w_dst_r == e_rt_r),
                        m_tnew_r, w_tnew_r);
        md_stall_s = hz.d_md_use && (md_busy_s || e_md_start_r);
        stall_s    = hz.d_valid && (rs_d_s[2] || rt_d_s[2] || md_stall_s);
        e_load_s   = hz.d_valid && !stall_s;
    end

    assign hz.stall    = stall_s;
    assign hz.fwd_rs_d = rs_d_s[1:0];
    assign hz.fwd_rt_d = rt_d_s[1:0];
    assign hz.fwd_rs_e = rs_e_s;
    assign hz.fwd_rt_e = rt_e_s;
    assign hz.fwd_rt_m = m_use_rt_r && w_live_s && (w_dst_r == m_rt_r);
    assign hz.md_busy  = md_busy_s;

    // Shadow pipeline advance; a stalled or empty D slot enters E as a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_vld_r <= 1'b0; e_use_rs_r <= 1'b0; e_use_rt_r <= 1'b0;
            e_md_start_r <= 1'b0; e_md_div_r <= 1'b0;
            e_dst_r <= '0; e_rs_r <= '0; e_rt_r <= '0; e_tnew_r <= '0;
            m_vld_r <= 1'b0; m_use_rt_r <= 1'b0; m_dst_r <= '0; m_rt_r <= '0; m_tnew_r <= '0;
            w_vld_r <= 1'b0; w_dst_r <= '0; w_tnew_r <= '0;
        end else begin
            w_vld_r      <= m_vld_r;
            w_dst_r      <= m_dst_r;
            w_tnew_r     <= sat_dec(m_tnew_r);
            m_vld_r      <= e_vld_r;
            m_use_rt_r   <= e_use_rt_r;
            m_dst_r      <= e_dst_r;
            m_rt_r       <= e_rt_r;
            m_tnew_r     <= sat_dec(e_tnew_r);
            e_vld_r      <= e_load_s && hz.d_wen;
            e_use_rs_r   <= e_load_s && hz.d_use_rs;
            e_use_rt_r   <= e_load_s && hz.d_use_rt;
            e_md_start_r <= e_load_s && hz.d_md_start;
            e_md_div_r   <= hz.d_md_div;
            e_dst_r      <= hz.d_dst;
            e_rs_r       <= hz.d_rs;
            e_rt_r       <= hz.d_rt;
            e_tnew_r     <= hz.d_tnew;
        end
    end

    // MDU busy counter, loaded as a mult/div leaves E.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (e_md_start_r) begin
            cnt_r <= e_md_div_r ? CW'(DIV_LAT) : CW'(MULT_LAT);
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule
